// File: rtl/bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary_seq
// Description : Sequential packed-BCD to binary converter. One digit per
//               clock, most significant digit first (acc = acc*10 + digit).
//               Words with any digit above 9 are rejected with err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_binary_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  // A single-digit build still needs a one-bit counter to stay legal.
  localparam int              CNT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   bcd_q,   bcd_d;
  logic [BIN_W-1:0]      acc_q,   acc_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [BIN_W-1:0]      bin_q,   bin_d;
  logic                  err_q,   err_d;

  logic                  any_bad;
  logic [3:0]            cur_digit;
  logic [BIN_W-1:0]      acc_next;

  // Flag the incoming word if any of its digits is outside 0..9.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  // Select the captured digit addressed by the down-counter.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) cur_digit = bcd_q[4*i +: 4];
    end
  end

  // acc*10 is built from shifts so no multiplier is inferred; wraps mod 2^BIN_W.
  assign acc_next = (acc_q << 3) + (acc_q << 1) + BIN_W'(cur_digit);

  // Next-state and datapath updates; everything holds unless stated.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d = bcd;
          if (any_bad) begin
            bin_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            acc_d   = '0;
            cnt_d   = CNT_TOP;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        acc_d = acc_next;
        if (cnt_q == '0) begin
          bin_d   = acc_next;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign bin  = bin_q;
  assign err  = err_q;
  assign done = (state_q == DONE);
  assign busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_binary_seq
// Description : Table-driven directed bench for bcd_to_binary_seq plus
//               hand-written sequences for start-ignore, mid-conversion
//               reset and back-to-back conversions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int WAIT_MAX = 20;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [4*DIGITS-1:0] bcd;
  logic [BIN_W-1:0]    bin;
  logic                done;
  logic                err;
  logic                busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] exp_bin;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .done  (done),
    .err   (err),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start pulse; returns sampled just after edge 0.
  task automatic issue_start(input logic [15:0] word);
    bcd   = word;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges after edge 0 until done is seen; busy must be high meanwhile.
  task automatic wait_done(input string name, output int lat);
    int bad_busy;
    lat      = 0;
    bad_busy = 0;
    while (!done && lat < WAIT_MAX) begin
      if (!busy) bad_busy++;
      tick();
      lat++;
    end
    check({name, " busy while converting"}, bad_busy, 0);
    check({name, " done reached"}, (lat < WAIT_MAX) ? 1 : 0, 1);
  endtask

  initial begin
    int lat;
    int t_first;
    int n_done;

    vecs[0] = '{16'h0000, 14'd0,    1'b0};
    vecs[1] = '{16'h9999, 14'd9999, 1'b0};
    vecs[2] = '{16'h1234, 14'd1234, 1'b0};
    vecs[3] = '{16'h12A4, 14'd0,    1'b1};
    vecs[4] = '{16'h0042, 14'd42,   1'b0};
    vecs[5] = '{16'hF000, 14'd0,    1'b1};
    vecs[6] = '{16'h0909, 14'd909,  1'b0};
    vecs[7] = '{16'h1000, 14'd1000, 1'b0};
    vecs[8] = '{16'h000B, 14'd0,    1'b1};
    vecs[9] = '{16'h0007, 14'd7,    1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    bcd   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset bin",  bin,  0);
    check("reset done", done, 0);
    check("reset err",  err,  0);
    check("reset busy", busy, 0);
    #2 rst_n = 1'b1;
    tick();
    check("idle after release done", done, 0);
    check("idle after release busy", busy, 0);

    // Table-driven conversions, each followed by an idle gap.
    for (int v = 0; v < 10; v++) begin
      issue_start(vecs[v].bcd);
      wait_done($sformatf("vec%0d", v), lat);
      check($sformatf("vec%0d latency", v), lat, vecs[v].exp_err ? 0 : DIGITS);
      check($sformatf("vec%0d bin", v), bin, vecs[v].exp_bin);
      check($sformatf("vec%0d err", v), err, vecs[v].exp_err);
      tick();
      check($sformatf("vec%0d done one cycle", v), done, 0);
      check($sformatf("vec%0d busy drops", v), busy, 0);
      tick();
      check($sformatf("vec%0d bin holds", v), bin, vecs[v].exp_bin);
      check($sformatf("vec%0d err holds", v), err, vecs[v].exp_err);
    end

    // start during CONV with a different word must be ignored.
    issue_start(16'h0500);
    tick();
    bcd   = 16'h0999;
    start = 1'b1;
    tick();
    start = 1'b0;
    bcd   = 16'h0777;
    wait_done("ignore", lat);
    check("ignore latency", lat, DIGITS - 2);
    check("ignore bin", bin, 500);
    check("ignore err", err, 0);
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) n_done++;
    end
    check("ignore extra done count", n_done, 0);

    // Async reset in the second CONV cycle aborts the conversion.
    issue_start(16'h8765);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort bin",  bin,  0);
    check("abort done", done, 0);
    check("abort err",  err,  0);
    check("abort busy", busy, 0);
    #2 rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done || busy) n_done++;
    end
    check("abort no later activity", n_done, 0);
    check("abort bin stays 0", bin, 0);

    // Back-to-back: new start in the first cycle after done.
    issue_start(16'h0001);
    wait_done("b2b first", lat);
    check("b2b first bin", bin, 1);
    t_first = cyc;
    tick();
    check("b2b idle busy", busy, 0);
    issue_start(16'h0010);
    wait_done("b2b second", lat);
    check("b2b second bin", bin, 10);
    check("b2b second err", err, 0);
    check("b2b spacing", cyc - t_first, DIGITS + 2);
    tick();
    check("b2b end done", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
